button_event_queue: RTL and testbench

// - Sits between the virtual button interface's 24-bit `buttons` vector and button-driven controllers.
// - Turns button press edges into a stream of button-index events with a valid/ready handshake.
// - Queues events in a small FIFO, so a consumer can act on each press once, in press order, at its own pace.
// - Reports events that could not be queued.

---
 rtl/button_event_queue.sv | 109 ++++++++++
 tb/tb_button_event_queue.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/button_event_queue.sv
// button_event_queue
// Converts rising edges on a level button vector into a queue of button-index
// events delivered over a valid/ready handshake, in press order.
//
// Ports:
//   CLK            - system clock, rising edge
//   RST_N          - synchronous active-low reset
//   buttons        - level button states, 1 = pressed
//   event_valid    - head of FIFO holds an event
//   event_index    - button index of head event (0 when not valid)
//   event_ready    - consumer accepts head event when valid & ready
//   overflow       - sticky: a press merged into an already pending press
//   clear_overflow - clears overflow (a simultaneous set wins)
//   pending_count  - number of queued events, 0..FIFO_DEPTH
module button_event_queue #(
  parameter int BUTTON_COUNT = 24,
  parameter int INDEX_WIDTH  = 5,
  parameter int FIFO_DEPTH   = 8,
  parameter int PTR_WIDTH    = 3
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [BUTTON_COUNT-1:0] buttons,
  output logic                    event_valid,
  output logic [INDEX_WIDTH-1:0]  event_index,
  input  logic                    event_ready,
  output logic                    overflow,
  input  logic                    clear_overflow,
  output logic [PTR_WIDTH:0]      pending_count
);

  localparam logic [PTR_WIDTH:0] DEPTH = (PTR_WIDTH + 1)'(FIFO_DEPTH);

  logic [BUTTON_COUNT-1:0] prev_buttons;
  logic [BUTTON_COUNT-1:0] pending;
  logic [BUTTON_COUNT-1:0] rise;
  logic [BUTTON_COUNT-1:0] taken;
  logic [BUTTON_COUNT-1:0] remain;
  logic [BUTTON_COUNT-1:0] sel_onehot;
  logic [INDEX_WIDTH-1:0]  sel_idx;
  logic                    found;
  logic                    pop;
  logic                    push;
  logic                    can_push;
  logic                    lost;
  logic [PTR_WIDTH-1:0]    wr_ptr;
  logic [PTR_WIDTH-1:0]    rd_ptr;
  logic [INDEX_WIDTH-1:0]  mem [FIFO_DEPTH];

  // Lowest-index pending button wins the single push slot of the cycle.
  always_comb begin
    sel_idx    = '0;
    sel_onehot = '0;
    found      = 1'b0;
    for (int unsigned i = 0; i < BUTTON_COUNT; i++) begin
      if (pending[i] && !found) begin
        sel_idx       = INDEX_WIDTH'(i);
        sel_onehot[i] = 1'b1;
        found         = 1'b1;
      end
    end
  end

  always_comb begin
    rise     = buttons & ~prev_buttons;
    pop      = event_valid & event_ready;
    can_push = (pending_count < DEPTH) | pop;
    push     = found & can_push;
    taken    = push ? sel_onehot : '0;
    remain   = pending & ~taken;
    // A press on a button that is still waiting to be queued is merged and lost.
    lost     = |(rise & remain);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      prev_buttons  <= buttons;
      pending       <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      pending_count <= '0;
      overflow      <= 1'b0;
    end else begin
      prev_buttons <= buttons;
      pending      <= remain | rise;
      if (push) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      if (push && !pop)
        pending_count <= pending_count + (PTR_WIDTH + 1)'(1);
      else if (pop && !push)
        pending_count <= pending_count - (PTR_WIDTH + 1)'(1);
      if (lost)
        overflow <= 1'b1;
      else if (clear_overflow)
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST_N && push) mem[wr_ptr] <= sel_idx;
  end

  // First-word-fall-through head, derived from registered state only.
  always_comb begin
    event_valid = (pending_count != '0);
    event_index = event_valid ? mem[rd_ptr] : '0;
  end

endmodule

// File: tb/tb_button_event_queue.sv
// tb_button_event_queue
// Directed scenarios plus randomized traffic against a queue-based
// behavioural model of the button event queue.
module tb_button_event_queue;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [23:0] buttons;
  logic        event_valid;
  logic [4:0]  event_index;
  logic        event_ready;
  logic        overflow;
  logic        clear_overflow;
  logic [3:0]  pending_count;

  button_event_queue #(
    .BUTTON_COUNT(24),
    .INDEX_WIDTH (5),
    .FIFO_DEPTH  (8),
    .PTR_WIDTH   (3)
  ) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .buttons       (buttons),
    .event_valid   (event_valid),
    .event_index   (event_index),
    .event_ready   (event_ready),
    .overflow      (overflow),
    .clear_overflow(clear_overflow),
    .pending_count (pending_count)
  );

  always #5 CLK = ~CLK;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model: a set of waiting buttons and an ordered event queue.
  bit [23:0] m_prev;
  bit        m_wait [24];
  int        m_q [$];
  bit        m_ovf;
  int        emitted [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit [23:0] r;
    bit        do_pop;
    int        pick;
    bit        lost;
    if (!RST_N) begin
      m_q.delete();
      foreach (m_wait[i]) m_wait[i] = 1'b0;
      m_ovf  = 1'b0;
      m_prev = buttons;
      return;
    end
    r      = buttons & ~m_prev;
    do_pop = (m_q.size() > 0) && event_ready;
    pick   = -1;
    if (m_q.size() < 8 || do_pop)
      for (int i = 0; i < 24; i++)
        if (m_wait[i]) begin pick = i; break; end
    if (do_pop) m_q.pop_front();
    if (pick >= 0) begin
      m_q.push_back(pick);
      m_wait[pick] = 1'b0;
    end
    lost = 1'b0;
    for (int i = 0; i < 24; i++) if (r[i] && m_wait[i]) lost = 1'b1;
    if (lost) m_ovf = 1'b1;
    else if (clear_overflow) m_ovf = 1'b0;
    for (int i = 0; i < 24; i++) if (r[i]) m_wait[i] = 1'b1;
    m_prev = buttons;
  endtask

  // One clock: model and DUT advance on the same edge, outputs sampled #1 later.
  task automatic step();
    bit accept;
    accept = event_valid && event_ready;
    if (accept) emitted.push_back(int'(event_index));
    @(posedge CLK);
    model_edge();
    #1;
    check("valid", event_valid, m_q.size() != 0);
    check("index", event_index, (m_q.size() != 0) ? m_q[0] : 0);
    check("count", pending_count, m_q.size());
    check("ovf",   overflow, m_ovf);
  endtask

  task automatic do_reset(input int cycles);
    RST_N = 1'b0;
    repeat (cycles) step();
    RST_N = 1'b1;
    emitted.delete();
  endtask

  initial begin
    RST_N = 1'b0; buttons = 24'h000001; event_ready = 1'b0; clear_overflow = 1'b0;
    #2;

    // Button held through reset produces nothing.
    do_reset(2);
    repeat (20) begin
      step();
      check("held_no_event", event_valid, 1'b0);
    end
    check("held_no_ovf", overflow, 1'b0);

    // Single press latency.
    buttons = '0; event_ready = 1'b1;
    step();
    buttons[5] = 1'b1;
    step();                                   // E0: pending
    check("lat_e0_valid", event_valid, 1'b0);
    step();                                   // E1: pushed
    check("lat_e1_valid", event_valid, 1'b1);
    check("lat_e1_index", event_index, 5);
    step();                                   // E2: accepted
    check("lat_e2_count", pending_count, 0);
    buttons = '0; step();

    // Simultaneous rises leave in ascending index order.
    emitted.delete();
    buttons = 24'h800009;
    repeat (6) step();
    check("sim_n",    emitted.size(), 3);
    if (emitted.size() == 3) begin
      check("sim_0", emitted[0], 0);
      check("sim_1", emitted[1], 3);
      check("sim_2", emitted[2], 23);
    end
    check("sim_ovf", overflow, 1'b0);
    buttons = '0; step();

    // Saturation, lost press and drain.
    event_ready = 1'b0;
    emitted.delete();
    for (int i = 0; i <= 8; i++) begin
      buttons[i] = 1'b1;
      step();
    end
    repeat (3) step();
    check("sat_count", pending_count, 8);
    check("sat_head",  event_index, 0);
    check("sat_ovf0",  overflow, 1'b0);
    buttons[8] = 1'b0; step();
    buttons[8] = 1'b1; step();
    check("sat_ovf1", overflow, 1'b1);
    event_ready = 1'b1;
    repeat (12) step();
    check("drain_n", emitted.size(), 9);
    for (int i = 0; i < 9 && i < emitted.size(); i++) check("drain_idx", emitted[i], i);
    check("drain_count", pending_count, 0);
    clear_overflow = 1'b1; step(); clear_overflow = 1'b0;
    check("ovf_cleared", overflow, 1'b0);
    buttons = '0; step();

    // Full FIFO: simultaneous pop and push keep count at 8.
    event_ready = 1'b0;
    emitted.delete();
    for (int i = 0; i < 8; i++) begin buttons[i] = 1'b1; step(); end
    buttons[10] = 1'b1;
    repeat (3) step();
    check("full_count", pending_count, 8);
    event_ready = 1'b1; step(); event_ready = 1'b0;
    check("full_pop0",  emitted.size() == 1 && emitted[0] == 0, 1'b1);
    check("full_count2", pending_count, 8);
    check("full_head",  event_index, 1);
    event_ready = 1'b1;
    repeat (10) step();
    check("full_n", emitted.size(), 9);
    if (emitted.size() == 9) check("full_last", emitted[8], 10);

    // Reset mid-operation discards queued and pending events.
    buttons = '0; event_ready = 1'b0; step();
    buttons = 24'h00003F; repeat (8) step();
    buttons = 24'h0FFFFF;
    step();
    check("mid_count_nz", pending_count != 0, 1'b1);
    do_reset(1);
    check("mid_valid", event_valid, 1'b0);
    check("mid_count", pending_count, 0);
    event_ready = 1'b1;
    repeat (10) begin
      step();
      check("mid_quiet", event_valid, 1'b0);
    end

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3) == 0) buttons[$urandom_range(23)] ^= 1'b1;
      if ($urandom_range(15) == 0) buttons = $urandom() & 24'hFFFFFF;
      event_ready    = ($urandom_range(9) < ((c / 500) % 2 == 0 ? 3 : 8));
      clear_overflow = ($urandom_range(15) == 0);
      RST_N          = ($urandom_range(399) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
